// File: rtl/gf_io_pkg.sv
// Shared helpers and types for the GF datapath output stage.
// Beat arithmetic lives here so the serializer and any future sibling agree on counter widths.
package gf_io_pkg;

    function automatic int beats(input int data_width, input int lanes);
        return data_width / lanes;
    endfunction

    // Counter is one bit wider than strictly needed so BEATS==1 still gets a legal 1-bit counter.
    function automatic int cnt_width(input int n_beats);
        return $clog2(n_beats) + 1;
    endfunction

    localparam int CNT_W = cnt_width(beats(32, 1));

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry holding register that parks a word accepted while the shifter is busy.
// A write always wins over a read; the serializer never issues both in the same cycle.
module ser_hold_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full
);

    always_ff @(posedge clk) begin
        if (reset) begin
            full    <= 1'b0;
            rd_data <= '0;
        end else if (wr_en) begin
            full    <= 1'b1;
            rd_data <= wr_data;
        end else if (rd_en) begin
            full    <= 1'b0;
        end
    end

endmodule

// File: rtl/output_serializer.sv
// Parallel-to-serial output stage: DATA_WIDTH-bit words in over valid/ready, LANES bits per cycle out,
// with first/last beat markers and a one-word holding buffer for gapless back-to-back words.
module output_serializer
    import gf_io_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 1,
    parameter int MSB_FIRST  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [LANES-1:0]      out_serial,
    output logic                  out_valid,
    output logic                  out_first,
    output logic                  out_last,
    output logic                  busy
);

    localparam int BEATS = beats(DATA_WIDTH, LANES);
    localparam int CW    = cnt_width(BEATS);
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

    if ((DATA_WIDTH % LANES) != 0) begin : g_bad_cfg
        $error("output_serializer: DATA_WIDTH must be a multiple of LANES");
    end

    ser_state_t            state, state_nxt;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_full;
    logic                  accept, load_pt, load_en;
    logic [DATA_WIDTH-1:0] load_word, src, src_rest;
    logic [LANES-1:0]      beat_out;

    assign in_ready  = !hold_full;
    assign accept    = in_valid && in_ready;
    assign busy      = out_valid || hold_full;

    // A load point is any cycle where the shifter can take a fresh word on the coming edge.
    assign load_pt   = (state == IDLE) || (cnt == LAST_CNT);
    assign load_en   = load_pt && (hold_full || accept);
    assign load_word = hold_full ? hold_data : in_data;
    assign src       = load_pt ? load_word : shreg;

    ser_hold_buf #(.WIDTH(DATA_WIDTH)) u_hold (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept && !load_pt),
        .rd_en   (load_pt && hold_full),
        .wr_data (in_data),
        .rd_data (hold_data),
        .full    (hold_full)
    );

    // The next beat is always taken from the edge of src that leaves first; the remainder shifts toward it.
    if (MSB_FIRST != 0) begin : g_msb
        assign beat_out = src[DATA_WIDTH-1 -: LANES];
        if (BEATS > 1) begin : g_sh
            assign src_rest = {src[DATA_WIDTH-LANES-1:0], {LANES{1'b0}}};
        end else begin : g_nosh
            assign src_rest = '0;
        end
    end else begin : g_lsb
        assign beat_out = src[LANES-1:0];
        if (BEATS > 1) begin : g_sh
            assign src_rest = {{LANES{1'b0}}, src[DATA_WIDTH-1:LANES]};
        end else begin : g_nosh
            assign src_rest = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load_en) state_nxt = SHIFT;
            SHIFT:   if (load_pt && !load_en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            shreg      <= '0;
            out_serial <= '0;
            out_valid  <= 1'b0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
        end else if (load_en) begin
            cnt        <= '0;
            shreg      <= src_rest;
            out_serial <= beat_out;
            out_valid  <= 1'b1;
            out_first  <= 1'b1;
            out_last   <= (BEATS == 1);
        end else if (load_pt) begin
            cnt        <= '0;
            out_serial <= '0;
            out_valid  <= 1'b0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            cnt        <= cnt + 1'b1;
            shreg      <= src_rest;
            out_serial <= beat_out;
            out_first  <= 1'b0;
            out_last   <= ((cnt + 1'b1) == LAST_CNT);
        end
    end

endmodule

// File: tb/tb_output_serializer.sv
module tb_output_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;

  logic [7:0]  a_data = '0;  logic a_valid = 1'b0; logic a_ready;
  logic [0:0]  a_ser;  logic a_ov, a_of, a_ol, a_busy;
  logic [7:0]  b_data = '0;  logic b_valid = 1'b0; logic b_ready;
  logic [1:0]  b_ser;  logic b_ov, b_of, b_ol, b_busy;
  logic [31:0] c_data = '0;  logic c_valid = 1'b0; logic c_ready;
  logic [31:0] c_ser;  logic c_ov, c_of, c_ol, c_busy;

  output_serializer #(.DATA_WIDTH(8), .LANES(1), .MSB_FIRST(0)) u_a (
    .clk(clk), .reset(reset), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .out_serial(a_ser), .out_valid(a_ov), .out_first(a_of), .out_last(a_ol), .busy(a_busy));
  output_serializer #(.DATA_WIDTH(8), .LANES(2), .MSB_FIRST(1)) u_b (
    .clk(clk), .reset(reset), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .out_serial(b_ser), .out_valid(b_ov), .out_first(b_of), .out_last(b_ol), .busy(b_busy));
  output_serializer #(.DATA_WIDTH(32), .LANES(32), .MSB_FIRST(0)) u_c (
    .clk(clk), .reset(reset), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
    .out_serial(c_ser), .out_valid(c_ov), .out_first(c_of), .out_last(c_ol), .busy(c_busy));

  typedef struct {
    logic [31:0] ser;
    logic        first;
    logic        last;
  } beat_t;

  beat_t qa[$], qb[$], qc[$];
  beat_t ea, eb, ec;
  logic [31:0] acap[$], bcap[$];
  int n_cmp = 0, n_bad = 0;
  int a_run = 0, a_max = 0, c_run = 0, c_max = 0;

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_bad++;
    $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] beat_val(input logic [31:0] w, input int width, input int lanes,
                                           input int msb, input int k);
    int sh;
    logic [31:0] mask;
    sh   = (msb != 0) ? width - (k + 1) * lanes : k * lanes;
    mask = (lanes >= 32) ? 32'hFFFF_FFFF : ((32'd1 << lanes) - 32'd1);
    return (w >> sh) & mask;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      qa.delete(); qb.delete(); qc.delete();
    end else begin
      if (a_valid && a_ready)
        for (int k = 0; k < 8; k++) qa.push_back('{beat_val(32'(a_data), 8, 1, 0, k), k == 0, k == 7});
      if (b_valid && b_ready)
        for (int k = 0; k < 4; k++) qb.push_back('{beat_val(32'(b_data), 8, 2, 1, k), k == 0, k == 3});
      if (c_valid && c_ready)
        qc.push_back('{c_data, 1'b1, 1'b1});
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (a_ov) begin
        if (qa.size() == 0) begin n_cmp++; fail("a_unexpected_beat", 32'(a_ser), 0); end
        else begin
          ea = qa.pop_front();
          n_cmp++; if (32'(a_ser) !== ea.ser) fail("a_serial", 32'(a_ser), ea.ser);
          n_cmp++; if (a_of !== ea.first) fail("a_first", 32'(a_of), 32'(ea.first));
          n_cmp++; if (a_ol !== ea.last) fail("a_last", 32'(a_ol), 32'(ea.last));
        end
        acap.push_back(32'(a_ser));
        a_run++;
        if (a_run > a_max) a_max = a_run;
      end else begin
        n_cmp++; if (32'({a_ser, a_of, a_ol}) !== 32'd0) fail("a_idle_outputs", 32'({a_ser, a_of, a_ol}), 0);
        a_run = 0;
      end
      if (b_ov) begin
        if (qb.size() == 0) begin n_cmp++; fail("b_unexpected_beat", 32'(b_ser), 0); end
        else begin
          eb = qb.pop_front();
          n_cmp++; if (32'(b_ser) !== eb.ser) fail("b_serial", 32'(b_ser), eb.ser);
          n_cmp++; if (b_of !== eb.first) fail("b_first", 32'(b_of), 32'(eb.first));
          n_cmp++; if (b_ol !== eb.last) fail("b_last", 32'(b_ol), 32'(eb.last));
        end
        bcap.push_back(32'(b_ser));
      end else begin
        n_cmp++; if (32'({b_ser, b_of, b_ol}) !== 32'd0) fail("b_idle_outputs", 32'({b_ser, b_of, b_ol}), 0);
      end
      if (c_ov) begin
        if (qc.size() == 0) begin n_cmp++; fail("c_unexpected_beat", c_ser, 0); end
        else begin
          ec = qc.pop_front();
          n_cmp++; if (c_ser !== ec.ser) fail("c_serial", c_ser, ec.ser);
          n_cmp++; if (c_of !== ec.first) fail("c_first", 32'(c_of), 32'(ec.first));
          n_cmp++; if (c_ol !== ec.last) fail("c_last", 32'(c_ol), 32'(ec.last));
        end
        c_run++;
        if (c_run > c_max) c_max = c_run;
      end else begin
        n_cmp++; if (c_ser !== 32'd0) fail("c_idle_serial", c_ser, 0);
        n_cmp++; if ({c_of, c_ol} !== 2'b00) fail("c_idle_marks", 32'({c_of, c_ol}), 0);
        c_run = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_send(input logic [7:0] w);
    int t = 0;
    a_valid = 1'b1;
    a_data  = w;
    while (!a_ready && t < 100) begin tick(); t++; end
    n_cmp++; if (a_ready !== 1'b1) fail("a_send_timeout", 32'(a_ready), 1);
    tick();
  endtask

  task automatic b_send(input logic [7:0] w);
    int t = 0;
    b_valid = 1'b1;
    b_data  = w;
    while (!b_ready && t < 100) begin tick(); t++; end
    n_cmp++; if (b_ready !== 1'b1) fail("b_send_timeout", 32'(b_ready), 1);
    tick();
  endtask

  task automatic drain_all();
    int t = 0;
    while ((a_busy || b_busy || c_busy) && t < 300) begin tick(); t++; end
    n_cmp++; if (a_busy !== 1'b0) fail("drain_a_busy", 32'(a_busy), 0);
    n_cmp++; if (b_busy !== 1'b0) fail("drain_b_busy", 32'(b_busy), 0);
    n_cmp++; if (c_busy !== 1'b0) fail("drain_c_busy", 32'(c_busy), 0);
    tick();
  endtask

  int exp_a5[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
  int exp_b4[4] = '{2, 3, 1, 0};

  initial begin
    int t;
    logic acc_a, acc_b, acc_c;

    reset = 1'b1;
    repeat (3) tick();
    n_cmp++; if (a_ov !== 1'b0) fail("rst_a_valid", 32'(a_ov), 0);
    n_cmp++; if (a_ready !== 1'b1) fail("rst_a_ready", 32'(a_ready), 1);
    n_cmp++; if (a_busy !== 1'b0) fail("rst_a_busy", 32'(a_busy), 0);
    n_cmp++; if (b_ov !== 1'b0) fail("rst_b_valid", 32'(b_ov), 0);
    n_cmp++; if (b_ready !== 1'b1) fail("rst_b_ready", 32'(b_ready), 1);
    n_cmp++; if (b_busy !== 1'b0) fail("rst_b_busy", 32'(b_busy), 0);
    n_cmp++; if (c_ov !== 1'b0) fail("rst_c_valid", 32'(c_ov), 0);
    n_cmp++; if (c_ready !== 1'b1) fail("rst_c_ready", 32'(c_ready), 1);
    n_cmp++; if (c_busy !== 1'b0) fail("rst_c_busy", 32'(c_busy), 0);
    reset = 1'b0;
    tick();

    acap.delete(); bcap.delete();
    a_send(8'hA5);
    a_valid = 1'b0;
    n_cmp++; if (a_ov !== 1'b1) fail("a5_beat0_valid", 32'(a_ov), 1);
    n_cmp++; if (a_of !== 1'b1) fail("a5_beat0_first", 32'(a_of), 1);
    b_send(8'hB4);
    b_valid = 1'b0;
    drain_all();
    n_cmp++; if (acap.size() != 8) fail("a5_beat_count", 32'(acap.size()), 8);
    for (int k = 0; k < 8 && k < acap.size(); k++) begin
      n_cmp++; if (acap[k] !== 32'(exp_a5[k])) fail("a5_bit", acap[k], 32'(exp_a5[k]));
    end
    n_cmp++; if (bcap.size() != 4) fail("b4_beat_count", 32'(bcap.size()), 4);
    for (int k = 0; k < 4 && k < bcap.size(); k++) begin
      n_cmp++; if (bcap[k] !== 32'(exp_b4[k])) fail("b4_lanes", bcap[k], 32'(exp_b4[k]));
    end

    a_max = 0;
    a_send(8'h01);
    a_send(8'h02);
    n_cmp++; if (a_ready !== 1'b0) fail("b2b_ready_low_hold_full", 32'(a_ready), 0);
    n_cmp++; if (a_busy !== 1'b1) fail("b2b_busy", 32'(a_busy), 1);
    a_send(8'h03);
    a_valid = 1'b0;
    drain_all();
    n_cmp++; if (a_max != 24) fail("b2b_gapless_beats", 32'(a_max), 24);

    a_max = 0;
    a_send(8'h3C);
    a_valid = 1'b0;
    t = 0;
    while (!a_ol && t < 50) begin tick(); t++; end
    n_cmp++; if (a_ol !== 1'b1) fail("lastbeat_seen", 32'(a_ol), 1);
    a_valid = 1'b1;
    a_data  = 8'h5A;
    tick();
    a_valid = 1'b0;
    n_cmp++; if (a_ready !== 1'b1) fail("lastbeat_hold_empty", 32'(a_ready), 1);
    n_cmp++; if (a_of !== 1'b1) fail("lastbeat_next_first", 32'(a_of), 1);
    drain_all();
    n_cmp++; if (a_max != 16) fail("lastbeat_gapless", 32'(a_max), 16);

    a_send(8'h11);
    a_send(8'h22);
    a_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (a_ov !== 1'b0) fail("midrst_valid", 32'(a_ov), 0);
    n_cmp++; if (a_busy !== 1'b0) fail("midrst_busy", 32'(a_busy), 0);
    n_cmp++; if (a_ready !== 1'b1) fail("midrst_ready", 32'(a_ready), 1);
    acap.delete();
    a_send(8'hFF);
    a_valid = 1'b0;
    drain_all();
    n_cmp++; if (acap.size() != 8) fail("midrst_ff_beats", 32'(acap.size()), 8);

    c_max = 0;
    c_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c_data = $urandom;
      n_cmp++; if (c_ready !== 1'b1) fail("c_stream_ready", 32'(c_ready), 1);
      tick();
    end
    c_valid = 1'b0;
    drain_all();
    n_cmp++; if (c_max != 4) fail("c_stream_run", 32'(c_max), 4);

    for (int i = 0; i < 600; i++) begin
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      acc_c = c_valid && c_ready;
      tick();
      if (acc_a || !a_valid) begin a_valid = ($urandom_range(0, 3) != 0); a_data = 8'($urandom); end
      if (acc_b || !b_valid) begin b_valid = ($urandom_range(0, 1) != 0); b_data = 8'($urandom); end
      if (acc_c || !c_valid) begin c_valid = ($urandom_range(0, 1) != 0); c_data = $urandom; end
    end
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
    drain_all();
    n_cmp++; if (qa.size() != 0) fail("final_qa_empty", 32'(qa.size()), 0);
    n_cmp++; if (qb.size() != 0) fail("final_qb_empty", 32'(qb.size()), 0);
    n_cmp++; if (qc.size() != 0) fail("final_qc_empty", 32'(qc.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
